// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder in front of a small word register file.
// Write (AW/W/B) and read (AR/R) channels run as independent FSMs.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = ADDR_WIDTH - 2;
  localparam int XW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  aw_held, w_held;
  logic [IW-1:0]         aw_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic [IW-1:0]         ar_idx;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_go, wr_hit, ar_hit;
  logic                  unused_addr_lsbs;

  function automatic logic in_range(input logic [IW-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  assign ar_idx = araddr[ADDR_WIDTH-1:2];

  // Readies are gated by reset so every output is low while it is held.
  assign awready = reset && (w_state == W_ACCEPT) && !aw_held;
  assign wready  = reset && (w_state == W_ACCEPT) && !w_held;
  assign arready = reset && (r_state == R_IDLE);
  assign bvalid  = (w_state == W_RESP);
  assign rvalid  = (r_state == R_DATA);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign wr_go  = (w_state == W_ACCEPT) && aw_held && w_held;
  assign wr_hit = wr_go && in_range(aw_idx);
  assign ar_hit = in_range(ar_idx);

  always_comb begin
    w_state_d = w_state;
    unique case (w_state)
      W_ACCEPT: if (wr_go) w_state_d = W_RESP;
      W_RESP:   if (bready) w_state_d = W_ACCEPT;
    endcase
  end

  always_comb begin
    r_state_d = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (rready) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_ACCEPT;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp   <= 2'b00;
    end else begin
      if (wr_go) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp   <= wr_hit ? 2'b00 : 2'b10;
      end
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  // Sampled before this edge's register write lands: same-edge reads see old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else if (ar_hs) begin
      rdata <= ar_hit ? regs[ar_idx[XW-1:0]] : '0;
      rresp <= ar_hit ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      for (int b = 0; b < SW; b++)
        if (wstrb_q[b])
          regs[aw_idx[XW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: stimulus queues expected B/R
// responses, a negedge monitor pops and compares them on each handshake.
module tb_axil_reg_slave;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [SW-1:0]     wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NR*DW-1:0]  reg_out;

  axil_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } rsp_t;

  logic [1:0] bq[$];
  rsp_t       rq[$];
  int         checks = 0;
  int         errors = 0;
  logic [DW-1:0] exp_regs [NR];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [DW-1:0] reg_at(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the requested valids and hold each until its handshake edge.
  task automatic issue(input bit aw, input bit w, input bit ar);
    bit pa, pw, pr, ha, hw, hr;
    pa = aw; pw = w; pr = ar;
    awvalid = aw; wvalid = w; arvalid = ar;
    for (int n = 0; n < 20 && (pa || pw || pr); n++) begin
      @(negedge clk);
      ha = pa && awready;
      hw = pw && wready;
      hr = pr && arready;
      tick();
      if (ha) begin pa = 0; awvalid = 0; end
      if (hw) begin pw = 0; wvalid = 0; end
      if (hr) begin pr = 0; arvalid = 0; end
    end
    if (pa || pw || pr) begin
      awvalid = 0; wvalid = 0; arvalid = 0;
      fail("handshake_timeout");
    end
  endtask

  task automatic drain();
    tick();
    for (int n = 0; n < 30; n++) begin
      if (!bvalid && !rvalid) return;
      tick();
    end
    fail("drain_timeout");
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [1:0] exp);
    awaddr = a; wdata = d; wstrb = s;
    bq.push_back(exp);
    issue(1, 1, 0);
    drain();
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] exp);
    rsp_t r;
    r.resp = exp; r.data = d;
    araddr = a;
    rq.push_back(r);
    issue(0, 0, 1);
    drain();
  endtask

  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset && bvalid && bready) begin
        if (bq.size() == 0) fail("b_unexpected");
        else chk("bresp", 64'(bresp), 64'(bq.pop_front()));
      end
      if (reset && rvalid && rready) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          r = rq.pop_front();
          chk("rresp", 64'(rresp), 64'(r.resp));
          chk("rdata", 64'(rdata), 64'(r.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    araddr = '0; arvalid = 0; bready = 1; rready = 1;
    for (int i = 0; i < NR; i++) exp_regs[i] = '0;

    tick();
    tick();
    chk("rst_awready", 64'(awready), 0);
    chk("rst_wready", 64'(wready), 0);
    chk("rst_arready", 64'(arready), 0);
    chk("rst_valids", 64'({bvalid, rvalid}), 0);
    chk("rst_regs_nz", 64'(|reg_out), 0);
    reset = 1;
    tick();
    chk("rel_readies", 64'({awready, wready, arready}), 64'(3'b111));

    // AW and W together: bvalid one edge after the handshake edge
    awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    bq.push_back(2'b00);
    issue(1, 1, 0);
    chk("t1_bvalid_early", 64'(bvalid), 0);
    tick();
    chk("t1_bvalid", 64'(bvalid), 1);
    chk("t1_reg1", 64'(reg_at(1)), 64'h0000_0000_DEAD_BEEF);
    tick();
    chk("t1_bvalid_drop", 64'(bvalid), 0);
    chk("t1_readies", 64'({awready, wready}), 64'(2'b11));
    exp_regs[1] = 32'hDEADBEEF;
    read(8'h04, 32'hDEADBEEF, 2'b00);

    // AW first, W three cycles later
    awaddr = 8'h08;
    bq.push_back(2'b00);
    issue(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_awready_low", 64'(awready), 0);
      chk("t2_bvalid_low", 64'(bvalid), 0);
      tick();
    end
    wdata = 32'h12345678; wstrb = 4'hF;
    issue(0, 1, 0);
    chk("t2_bvalid_early", 64'(bvalid), 0);
    tick();
    chk("t2_bvalid", 64'(bvalid), 1);
    chk("t2_reg2", 64'(reg_at(2)), 64'h1234_5678);
    exp_regs[2] = 32'h12345678;
    drain();

    // Byte-lane strobe
    write(8'h0C, 32'hFFFFFFFF, 4'hF, 2'b00);
    write(8'h0C, 32'h000000AB, 4'b0001, 2'b00);
    chk("t3_reg3", 64'(reg_at(3)), 64'hFFFF_FFAB);
    exp_regs[3] = 32'hFFFFFFAB;
    write(8'h0E, 32'h5A5A0000, 4'b0100, 2'b00);
    chk("t3_reg3_lane2", 64'(reg_at(3)), 64'hFF5A_FFAB);
    exp_regs[3] = 32'hFF5AFFAB;

    // Out-of-range write and read
    write(8'h40, 32'h55555555, 4'hF, 2'b10);
    for (int i = 0; i < NR; i++)
      chk($sformatf("t4_reg%0d", i), 64'(reg_at(i)), 64'(exp_regs[i]));
    read(8'h40, 32'h0, 2'b10);
    write(8'h20, 32'h11111111, 4'hF, 2'b10);
    read(8'hFC, 32'h0, 2'b10);

    // Read with rready held low
    rready = 0;
    araddr = 8'h04;
    begin
      rsp_t r;
      r.resp = 2'b00; r.data = 32'hDEADBEEF;
      rq.push_back(r);
    end
    issue(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_rvalid", 64'(rvalid), 1);
      chk("t5_rdata", 64'(rdata), 64'hDEAD_BEEF);
      chk("t5_arready", 64'(arready), 0);
      tick();
    end
    rready = 1;
    tick();
    chk("t5_rvalid_drop", 64'(rvalid), 0);
    chk("t5_arready_back", 64'(arready), 1);

    // AR handshake on the write edge of the same register sees old data
    awaddr = 8'h14; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    bq.push_back(2'b00);
    issue(1, 1, 0);
    araddr = 8'h14;
    begin
      rsp_t r;
      r.resp = 2'b00; r.data = 32'h0;
      rq.push_back(r);
    end
    issue(0, 0, 1);
    drain();
    read(8'h14, 32'hCAFEF00D, 2'b00);

    // Reset with B and R both pending
    bready = 0; rready = 0;
    awaddr = 8'h18; wdata = 32'h0BADCAFE; wstrb = 4'hF;
    issue(1, 1, 0);
    tick();
    araddr = 8'h04;
    issue(0, 0, 1);
    chk("t6_pending", 64'({bvalid, rvalid}), 64'(2'b11));
    #2;
    reset = 0;
    #1;
    chk("t6_rst_valids", 64'({bvalid, rvalid}), 0);
    chk("t6_rst_readies", 64'({awready, wready, arready}), 0);
    chk("t6_rst_regs_nz", 64'(|reg_out), 0);
    bready = 1; rready = 1;
    tick();
    tick();
    reset = 1;
    tick();
    chk("t6_rel_readies", 64'({awready, wready, arready}), 64'(3'b111));
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_resp", 64'({bvalid, rvalid}), 0);
      tick();
    end
    read(8'h04, 32'h0, 2'b00);

    chk("bq_empty", 64'(bq.size()), 0);
    chk("rq_empty", 64'(rq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) fronting a small register file.
- Answers the write and read transactions issued by the team's AXI-Lite initiator controller.
- Independent write path (AW/W/B) and read path (AR/R), each with its own state machine.
- Register contents are exported for use by downstream logic.

Parameters:
- ADDR_WIDTH, 8, byte-address width of awaddr/araddr.
- DATA_WIDTH, 32, data width; must be a multiple of 8; strobe width is DATA_WIDTH/8.
- NUM_REGS, 8, number of word registers; register index = addr[ADDR_WIDTH-1:2].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte-lane write strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register file; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (reset=0, asynchronous): write FSM to W_ACCEPT, read FSM to R_IDLE, all holding flags cleared, all registers 0. While reset=0, all outputs are 0, including awready, wready and arready.
- Reset mid-transaction discards any pending address, data or response; no partial register write occurs.
- Handshake: a transfer occurs on a rising edge where valid && ready are both 1. bvalid and rvalid, once raised, stay high with bresp/rresp/rdata stable until the matching ready is seen.
- Address decode: addr[1:0] is ignored. A decoded index >= NUM_REGS is out of range.
- Write FSM states: W_ACCEPT, W_RESP.
  - W_ACCEPT: awready = !aw_held; wready = !w_held.
    - An AW handshake latches awaddr and sets aw_held.
    - A W handshake latches wdata/wstrb and sets w_held.
    - AW and W may arrive in either order or in the same cycle.
  - When both AW and W are held (including the cycle both handshake together), the next edge:
    - writes the register: each byte lane whose wstrb bit is 1 is updated; other lanes keep their value;
    - sets bresp;
    - raises bvalid;
    - clears both holding flags;
    - enters W_RESP.
  - Latency: with AW and W both handshaking at edge N, the register is updated and bvalid rises at edge N+1.
  - Out-of-range write: no register changes, bresp = 2'b10.
  - W_RESP: awready = wready = 0. On a bready handshake, bvalid drops and the FSM returns to W_ACCEPT; readies reassert in the following cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = 1. An AR handshake captures rdata from the current register value and sets rresp, then the FSM enters R_DATA with rvalid = 1.
  - Out-of-range read: rdata = 0, rresp = 2'b10.
  - R_DATA: arready = 0. On an rready handshake, rvalid drops and the FSM returns to R_IDLE.
  - Throughput: at most one read per 2 cycles.
- Simultaneous events:
  - The read and write paths run fully concurrently.
  - If a register write and an AR handshake to the same index occur on the same edge, the read returns the pre-write value.
- reg_out reflects the register file directly, so new values are visible the cycle after the write edge.
- Protocol assumption: valid signals obey AXI rules (no drop before ready). Behaviour on violation is undefined.

Test Plan:
- Reset, then AW and W together, addr 0x04, wdata 0xDEADBEEF, wstrb 4'hF, bready=1 -> bvalid one cycle later, bresp 00, reg 1 reads 0xDEADBEEF, awready/wready back to 1 after the B handshake.
- AW addr 0x08 first; W 0x12345678 three cycles later -> awready=0 while waiting; bvalid the cycle after the W handshake; reg_out[2] = 0x12345678.
- reg 3 = 0xFFFFFFFF, then write 0x000000AB with wstrb 4'b0001 -> reg 3 = 0xFFFFFFAB.
- Write addr 0x40 (index 16, out of range) -> bresp 10, reg_out unchanged. Read addr 0x40 -> rresp 10, rdata 0.
- Read addr 0x04 with rready held low 5 cycles -> rvalid and rdata 0xDEADBEEF stable throughout, arready=0; rvalid drops after rready=1.
- Assert reset low while bvalid=1 and rvalid=1 pending -> bvalid, rvalid and all registers 0 immediately; after release, readies return to 1 and no response is emitted.
